// File: rtl/timetagging_buffer_capture_sequencer.sv
// Sequences one capture/readout cycle of the timetagging sample buffer per command:
// SW resets, banking, arm/start/stop, depth-report wait, readout launch and beat counting.
module timetagging_buffer_capture_sequencer #(
  parameter int BANKING_MODE_WIDTH = 2,
  parameter int WINDOW_WIDTH       = 32,
  parameter int DEPTH_TIMEOUT      = 4096
) (
  input  logic                                       ps_clk,
  input  logic                                       ps_reset_n,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic [BANKING_MODE_WIDTH+WINDOW_WIDTH-1:0] cmd_data,
  input  logic                                       stop_req,
  input  logic                                       abort,
  output logic                                       cap_rst_valid,
  input  logic                                       cap_rst_ready,
  output logic                                       ro_rst_valid,
  input  logic                                       ro_rst_ready,
  output logic                                       bank_valid,
  input  logic                                       bank_ready,
  output logic [BANKING_MODE_WIDTH-1:0]              bank_data,
  output logic                                       ass_valid,
  input  logic                                       ass_ready,
  output logic [2:0]                                 ass_data,
  output logic                                       ro_start_valid,
  input  logic                                       ro_start_ready,
  input  logic                                       sdepth_valid,
  input  logic                                       sdepth_ready,
  input  logic                                       tdepth_valid,
  input  logic                                       tdepth_ready,
  input  logic                                       rd_valid,
  input  logic                                       rd_ready,
  input  logic                                       rd_last,
  output logic                                       busy,
  output logic                                       done,
  output logic [1:0]                                 error,
  output logic [31:0]                                beat_count
);

  localparam int DCW = $clog2(DEPTH_TIMEOUT + 1);
  localparam logic [DCW-1:0]          DEPTH_ONE  = DCW'(1);
  localparam logic [DCW-1:0]          DEPTH_LAST = DCW'(DEPTH_TIMEOUT - 1);
  localparam logic [WINDOW_WIDTH-1:0] WIN_ONE    = WINDOW_WIDTH'(1);
  localparam logic [WINDOW_WIDTH-1:0] WIN_ZERO   = '0;

  typedef enum logic [3:0] {
    IDLE, CAP_RST, RO_RST, BANK, ARM, START, WINDOW, STOP,
    WAIT_DEPTH, RO_START, READOUT, DONE, ABORT_CAP, ABORT_RO
  } state_t;

  state_t                  state, state_next;
  logic [WINDOW_WIDTH-1:0] window_cycles;
  logic [WINDOW_WIDTH-1:0] win_count;
  logic [DCW-1:0]          depth_count;
  logic                    s_seen, t_seen;
  logic                    abort_hit, window_end, timeout_hit, cmd_accept, beat;

  assign cmd_accept  = (state == IDLE) && cmd_valid && cmd_ready;
  assign abort_hit   = abort && !(state inside {IDLE, DONE, ABORT_CAP, ABORT_RO});
  assign window_end  = stop_req || ((window_cycles != WIN_ZERO) && (win_count == window_cycles - WIN_ONE));
  assign timeout_hit = (state == WAIT_DEPTH) && !(s_seen && t_seen) && (depth_count == DEPTH_LAST);
  assign beat        = rd_valid && rd_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (cmd_accept)                       state_next = CAP_RST;
      CAP_RST:    if (cap_rst_valid && cap_rst_ready)   state_next = RO_RST;
      RO_RST:     if (ro_rst_valid && ro_rst_ready)     state_next = BANK;
      BANK:       if (bank_valid && bank_ready)         state_next = ARM;
      ARM:        if (ass_valid && ass_ready)           state_next = START;
      START:      if (ass_valid && ass_ready)           state_next = WINDOW;
      WINDOW:     if (window_end)                       state_next = STOP;
      STOP:       if (ass_valid && ass_ready)           state_next = WAIT_DEPTH;
      WAIT_DEPTH: if (s_seen && t_seen)                 state_next = RO_START;
                  else if (timeout_hit)                 state_next = ABORT_CAP;
      RO_START:   if (ro_start_valid && ro_start_ready) state_next = READOUT;
      READOUT:    if (beat && rd_last)                  state_next = DONE;
      DONE:                                             state_next = IDLE;
      ABORT_CAP:  if (cap_rst_valid && cap_rst_ready)   state_next = ABORT_RO;
      ABORT_RO:   if (ro_rst_valid && ro_rst_ready)     state_next = DONE;
      default:                                          state_next = IDLE;
    endcase
    if (abort_hit) state_next = ABORT_CAP;
  end

  // Outputs are decoded from the next state so each write's valid rises on state entry.
  always_ff @(posedge ps_clk or negedge ps_reset_n) begin
    if (!ps_reset_n) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cap_rst_valid  <= 1'b0;
      ro_rst_valid   <= 1'b0;
      bank_valid     <= 1'b0;
      ass_valid      <= 1'b0;
      ro_start_valid <= 1'b0;
      ass_data       <= 3'b000;
      bank_data      <= '0;
      window_cycles  <= '0;
      error          <= 2'd0;
      beat_count     <= 32'd0;
      s_seen         <= 1'b0;
      t_seen         <= 1'b0;
      win_count      <= '0;
      depth_count    <= '0;
    end else begin
      state          <= state_next;
      cmd_ready      <= (state_next == IDLE);
      busy           <= (state_next != IDLE);
      done           <= (state_next == DONE);
      cap_rst_valid  <= (state_next inside {CAP_RST, ABORT_CAP});
      ro_rst_valid   <= (state_next inside {RO_RST, ABORT_RO});
      bank_valid     <= (state_next == BANK);
      ass_valid      <= (state_next inside {ARM, START, STOP});
      ro_start_valid <= (state_next == RO_START);

      case (state_next)
        ARM:     ass_data <= 3'b100;
        START:   ass_data <= 3'b010;
        STOP:    ass_data <= 3'b001;
        default: ass_data <= ass_data;
      endcase

      win_count   <= (state == WINDOW) ? win_count + WIN_ONE : WIN_ZERO;
      depth_count <= (state == WAIT_DEPTH) ? depth_count + DEPTH_ONE : '0;

      if (cmd_accept) begin
        bank_data     <= cmd_data[BANKING_MODE_WIDTH+WINDOW_WIDTH-1 -: BANKING_MODE_WIDTH];
        window_cycles <= cmd_data[WINDOW_WIDTH-1:0];
        error         <= 2'd0;
        beat_count    <= 32'd0;
        s_seen        <= 1'b0;
        t_seen        <= 1'b0;
      end else begin
        // Depth reports may arrive any time after capture reset, not only in WAIT_DEPTH.
        if (sdepth_valid && sdepth_ready) s_seen <= 1'b1;
        if (tdepth_valid && tdepth_ready) t_seen <= 1'b1;
        if ((state == READOUT) && beat && (beat_count != 32'hFFFF_FFFF))
          beat_count <= beat_count + 32'd1;
        if (abort_hit)        error <= 2'd2;
        else if (timeout_hit) error <= 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_timetagging_buffer_capture_sequencer.sv
// Bench for the capture sequencer: table of full-cycle commands plus hand-written
// abort, zero-window and mid-window reset sequences.
module tb_timetagging_buffer_capture_sequencer;

  logic        ps_clk = 1'b0;
  logic        ps_reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [33:0] cmd_data = '0;
  logic        stop_req = 1'b0;
  logic        abort = 1'b0;
  logic        cap_rst_valid, cap_rst_ready;
  logic        ro_rst_valid, ro_rst_ready;
  logic        bank_valid, bank_ready;
  logic [1:0]  bank_data;
  logic        ass_valid, ass_ready;
  logic [2:0]  ass_data;
  logic        ro_start_valid, ro_start_ready;
  logic        sdepth_valid, sdepth_ready, tdepth_valid, tdepth_ready;
  logic        rd_valid, rd_ready, rd_last;
  logic        busy, done;
  logic [1:0]  error;
  logic [31:0] beat_count;

  always #5 ps_clk = ~ps_clk;

  timetagging_buffer_capture_sequencer #(
    .BANKING_MODE_WIDTH(2), .WINDOW_WIDTH(32), .DEPTH_TIMEOUT(16)
  ) dut (
    .ps_clk(ps_clk), .ps_reset_n(ps_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .stop_req(stop_req), .abort(abort),
    .cap_rst_valid(cap_rst_valid), .cap_rst_ready(cap_rst_ready),
    .ro_rst_valid(ro_rst_valid), .ro_rst_ready(ro_rst_ready),
    .bank_valid(bank_valid), .bank_ready(bank_ready), .bank_data(bank_data),
    .ass_valid(ass_valid), .ass_ready(ass_ready), .ass_data(ass_data),
    .ro_start_valid(ro_start_valid), .ro_start_ready(ro_start_ready),
    .sdepth_valid(sdepth_valid), .sdepth_ready(sdepth_ready),
    .tdepth_valid(tdepth_valid), .tdepth_ready(tdepth_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done), .error(error), .beat_count(beat_count)
  );

  // Channel index: 0 cap_rst, 1 ro_rst, 2 bank, 3 ass, 4 ro_start
  logic [4:0] vld, rdy, hs, hs_prev, vld_prev;
  assign vld = {ro_start_valid, ass_valid, bank_valid, ro_rst_valid, cap_rst_valid};
  assign cap_rst_ready  = rdy[0];
  assign ro_rst_ready   = rdy[1];
  assign bank_ready     = rdy[2];
  assign ass_ready      = rdy[3];
  assign ro_start_ready = rdy[4];

  // Bench configuration (written by the main sequence only)
  int delay = 0, depth_mode = 0, n_beats_cfg = 0;
  logic send_last = 1'b1;

  // Observations (written by the environment only)
  int vcnt[5];
  int xfer[5];
  int vcyc, stab, drop_cnt, done_cnt, ass_n, beats_sent, rd_left;
  int win_tb, win_meas, wait_tb, wait_meas;
  logic in_win, in_wait;
  logic [8:0] ass_seq;
  logic [2:0] ass_prev;
  logic [1:0] bank_prev;

  int total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin : env
    rdy = '0; hs = '0; hs_prev = '0; vld_prev = '0;
    rd_valid = 0; rd_ready = 0; rd_last = 0;
    sdepth_valid = 0; sdepth_ready = 0; tdepth_valid = 0; tdepth_ready = 0;
    in_win = 0; in_wait = 0; rd_left = 0; ass_prev = '0; bank_prev = '0;
    for (int i = 0; i < 5; i++) begin vcnt[i] = 0; xfer[i] = 0; end
    forever begin
      @(negedge ps_clk);
      if (!ps_reset_n) begin
        in_win = 0; in_wait = 0; rd_left = 0; rdy = '0; hs_prev = '0; vld_prev = '0;
        rd_valid = 0; rd_ready = 0; rd_last = 0;
        sdepth_valid = 0; sdepth_ready = 0; tdepth_valid = 0; tdepth_ready = 0;
        for (int i = 0; i < 5; i++) vcnt[i] = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          for (int i = 0; i < 5; i++) xfer[i] = 0;
          vcyc = 0; stab = 0; drop_cnt = 0; done_cnt = 0; ass_n = 0; ass_seq = '0;
          beats_sent = 0; rd_left = 0; in_win = 0; in_wait = 0;
          win_tb = 0; wait_tb = 0; win_meas = -1; wait_meas = -1;
        end
        if (rd_left > 0) begin
          rd_valid = 1; rd_ready = 1; rd_last = send_last && (rd_left == 1);
          rd_left--; beats_sent++;
        end else begin
          rd_valid = 0; rd_ready = 0; rd_last = 0;
        end
        if (done) done_cnt++;
        if (in_win) begin
          if (ass_valid && ass_data == 3'b001) begin win_meas = win_tb; in_win = 0; end
          else win_tb++;
        end
        if (in_wait) begin
          if (cap_rst_valid || ro_start_valid) begin wait_meas = wait_tb; in_wait = 0; end
          else wait_tb++;
        end
        sdepth_valid = in_wait && (wait_tb == 5);
        sdepth_ready = sdepth_valid;
        tdepth_valid = sdepth_valid && (depth_mode == 0);
        tdepth_ready = tdepth_valid;
        for (int i = 0; i < 5; i++) begin
          if (!vld[i]) vcnt[i] = 0;
          else if (hs_prev[i] || vcnt[i] == 0) vcnt[i] = 1;
          else vcnt[i]++;
          rdy[i] = (delay == 0) || (vcnt[i] > delay);
          hs[i]  = vld[i] && rdy[i];
          if (vld[i]) vcyc++;
          if (hs[i]) xfer[i]++;
          if (vld_prev[i] && !hs_prev[i] && !vld[i]) drop_cnt++;
        end
        if (vld[3] && vld_prev[3] && !hs_prev[3] && ass_data != ass_prev) stab++;
        if (vld[2] && vld_prev[2] && !hs_prev[2] && bank_data != bank_prev) stab++;
        if (hs[3]) begin
          ass_seq = {ass_seq[5:0], ass_data}; ass_n++;
          if (ass_data == 3'b010) begin in_win = 1; win_tb = 0; end
          if (ass_data == 3'b001) begin in_wait = 1; wait_tb = 0; end
        end
        if (hs[4]) rd_left = n_beats_cfg;
        hs_prev = hs; vld_prev = vld; ass_prev = ass_data; bank_prev = bank_data;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] b, input logic [31:0] w);
    int n = 0;
    @(posedge ps_clk); #1;
    cmd_data = {b, w}; cmd_valid = 1'b1;
    do begin @(negedge ps_clk); #1; n++; end while (!cmd_ready && n < 50);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge ps_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(negedge ps_clk); #1; n++; end
    repeat (3) begin @(negedge ps_clk); #1; end
  endtask

  typedef struct {
    logic [1:0]  bank;
    logic [31:0] win;
    int delay; int mode; logic stop; int beats;
    int exp_err; int exp_bc; int exp_win; int exp_wait;
    int exp_cap; int exp_ros; int exp_tot; int exp_vcyc;
  } vec_t;
  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    delay = v.delay; depth_mode = v.mode; n_beats_cfg = v.beats; send_last = 1'b1;
    stop_req = v.stop;
    send_cmd(v.bank, v.win);
    wait_done(5000);
    stop_req = 1'b0;
    chk({t, "_done_pulse"}, done_cnt, 1);
    chk({t, "_error"}, error, v.exp_err);
    chk({t, "_beat_count"}, beat_count, v.exp_bc);
    chk({t, "_window_cycles"}, win_meas, v.exp_win);
    chk({t, "_depth_wait"}, wait_meas, v.exp_wait);
    chk({t, "_ass_count"}, ass_n, 3);
    chk({t, "_ass_seq"}, ass_seq, 9'b100_010_001);
    chk({t, "_cap_xfers"}, xfer[0], v.exp_cap);
    chk({t, "_ro_start_xfers"}, xfer[4], v.exp_ros);
    chk({t, "_total_xfers"}, xfer[0] + xfer[1] + xfer[2] + xfer[3] + xfer[4], v.exp_tot);
    chk({t, "_valid_cycles"}, vcyc, v.exp_vcyc);
    chk({t, "_data_stable"}, stab, 0);
    chk({t, "_valid_drops"}, drop_cnt, 0);
    chk({t, "_bank_data"}, bank_data, v.bank);
    chk({t, "_idle"}, {busy, cmd_ready}, 2'b01);
    $display("vector %0d: bank=%0d win=%0d delay=%0d err=%0d beats=%0d window=%0d wait=%0d",
             idx, v.bank, v.win, v.delay, error, beat_count, win_meas, wait_meas);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int n;
    //            bank  win      dly md stop beats err bc  win wait cap ros tot vcyc
    vecs[0] = '{2'd1, 32'd100, 0, 0, 1'b0, 64, 0, 64, 100, 6, 1, 1, 7, 7};
    vecs[1] = '{2'd2, 32'd5,   7, 0, 1'b0, 3,  0, 3,  5,   6, 1, 1, 7, 56};
    vecs[2] = '{2'd3, 32'd1,   0, 0, 1'b1, 1,  0, 1,  1,   6, 1, 1, 7, 7};
    vecs[3] = '{2'd0, 32'd4,   0, 0, 1'b1, 2,  0, 2,  1,   6, 1, 1, 7, 7};
    vecs[4] = '{2'd2, 32'd2,   3, 1, 1'b0, 0,  1, 0,  2,   16, 2, 0, 8, 32};

    repeat (3) @(negedge ps_clk);
    #1;
    chk("reset_outputs", {cmd_ready, busy, done, error, beat_count, ass_data, bank_data, vld}, 0);
    $display("reset: outputs=%0h", {cmd_ready, busy, done, error, beat_count, ass_data, bank_data, vld});
    ps_reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Abort during readout after 10 beats, then a fresh command must clear error.
    delay = 0; depth_mode = 0; n_beats_cfg = 10; send_last = 1'b0;
    send_cmd(2'd1, 32'd3);
    n = 0;
    while (beats_sent < 10 && n < 500) begin @(negedge ps_clk); #1; n++; end
    repeat (2) begin @(negedge ps_clk); #1; end
    abort = 1'b1;
    @(negedge ps_clk); #1;
    abort = 1'b0;
    wait_done(500);
    chk("rdabort_error", error, 2);
    chk("rdabort_beat_count", beat_count, 10);
    chk("rdabort_cap_xfers", xfer[0], 2);
    chk("rdabort_ro_xfers", xfer[1], 2);
    chk("rdabort_done_pulse", done_cnt, 1);
    $display("abort in readout: err=%0d beats=%0d cap=%0d ro=%0d", error, beat_count, xfer[0], xfer[1]);
    n_beats_cfg = 4; send_last = 1'b1;
    send_cmd(2'd2, 32'd3);
    chk("newcmd_error_cleared", error, 0);
    wait_done(500);
    chk("newcmd_beat_count", beat_count, 4);
    chk("newcmd_error", error, 0);
    $display("cmd after abort: err=%0d beats=%0d", error, beat_count);

    // Abort while the arm write is stalled: valid must drop the next cycle.
    delay = 7; n_beats_cfg = 4;
    send_cmd(2'd1, 32'd3);
    n = 0;
    while (!ass_valid && n < 200) begin @(negedge ps_clk); #1; n++; end
    abort = 1'b1;
    @(negedge ps_clk); #1;
    abort = 1'b0;
    chk("armabort_valid_dropped", ass_valid, 0);
    wait_done(500);
    chk("armabort_error", error, 2);
    chk("armabort_ass_count", ass_n, 0);
    chk("armabort_cap_xfers", xfer[0], 2);
    chk("armabort_valid_drops", drop_cnt, 1);
    $display("abort in arm: err=%0d ass=%0d cap=%0d drops=%0d", error, ass_n, xfer[0], drop_cnt);

    // Zero window holds until stop_req; STOP follows one cycle later.
    delay = 0; n_beats_cfg = 5;
    send_cmd(2'd1, 32'd0);
    n = 0;
    while (!in_win && n < 200) begin @(negedge ps_clk); #1; n++; end
    repeat (150) begin @(negedge ps_clk); #1; end
    chk("win0_holds", {busy, ass_valid}, 2'b10);
    stop_req = 1'b1;
    wait_done(500);
    stop_req = 1'b0;
    chk("win0_window_cycles", win_meas, 150);
    chk("win0_beat_count", beat_count, 5);
    chk("win0_error", error, 0);
    $display("zero window: window=%0d beats=%0d err=%0d", win_meas, beat_count, error);

    // Asynchronous reset in the middle of the window.
    send_cmd(2'd3, 32'd1000);
    n = 0;
    while (!in_win && n < 200) begin @(negedge ps_clk); #1; n++; end
    repeat (10) begin @(negedge ps_clk); #1; end
    ps_reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {cmd_ready, busy, done, error, beat_count, ass_data, bank_data, vld}, 0);
    $display("mid-window reset: outputs=%0h", {cmd_ready, busy, done, error, beat_count, ass_data, bank_data, vld});
    repeat (2) @(negedge ps_clk);
    #1;
    ps_reset_n = 1'b1;
    run_vec(vecs[0], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
